// File: rtl/cosim_reset_sequencer.sv
// Turns one async reset into NUM_CHANNELS channel resets that are released in order, each
// after the previous channel acks. Then counts run cycles and raises finish at a programmable limit.
module cosim_reset_sequencer #(
  parameter int NUM_CHANNELS    = 2,
  parameter int HOLD_CYCLES     = 4,
  parameter int STAGGER_CYCLES  = 1,
  parameter int ACK_TIMEOUT     = 256,
  parameter int CYCLE_CNT_WIDTH = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CYCLE_CNT_WIDTH-1:0]    cycle_limit,
  input  logic                          cycle_limit_valid,
  input  logic                          sw_reset_req,
  input  logic [NUM_CHANNELS-1:0]       chan_rst_ack,
  output logic [NUM_CHANNELS-1:0]       chan_rst,
  output logic                          ready,
  output logic                          timeout_err,
  output logic [$clog2(NUM_CHANNELS):0] err_chan,
  output logic [CYCLE_CNT_WIDTH-1:0]    cycle_count,
  output logic                          finish,
  output logic [2:0]                    state_dbg
);

  localparam int CW = $clog2(NUM_CHANNELS) + 1;
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam int SW = $clog2(STAGGER_CYCLES + 1);

  localparam logic [CW-1:0] LAST_CHAN = CW'(NUM_CHANNELS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [AW-1:0] WAIT_LAST = AW'(ACK_TIMEOUT - 1);
  localparam logic [SW-1:0] STAG_LAST = SW'(STAGGER_CYCLES - 1);
  localparam logic [CYCLE_CNT_WIDTH-1:0] CNT_MAX = '1;

  // ARM is the single edge between the last ack and ready rising.
  typedef enum logic [2:0] {
    S_HOLD    = 3'd0,
    S_RELEASE = 3'd1,
    S_STAGGER = 3'd2,
    S_ARM     = 3'd3,
    S_RUN     = 3'd4,
    S_DONE    = 3'd5,
    S_ERROR   = 3'd6
  } state_t;

  state_t                      state;
  logic [CW-1:0]               chan;
  logic [HW-1:0]               hold_cnt;
  logic [AW-1:0]               wait_cnt;
  logic [SW-1:0]               stag_cnt;
  logic [CYCLE_CNT_WIDTH-1:0]  limit_q;
  logic                        limit_valid_q;
  logic                        ack_cur;
  logic [CYCLE_CNT_WIDTH-1:0]  cnt_next;

  // Handshake: chan_rst[i] falling is the request, chan_rst_ack[i] high is the response; it is
  // only sampled while RELEASE waits on channel i, so early, late or dropping acks are ignored.
  always_comb begin
    ack_cur = 1'b0;
    for (int j = 0; j < NUM_CHANNELS; j++) begin
      if (chan == CW'(j)) ack_cur = chan_rst_ack[j];
    end
  end

  assign cnt_next  = cycle_count + CYCLE_CNT_WIDTH'(1);
  assign state_dbg = state;

  // Reset vector with channels [idx..N-1] held and channels below idx released.
  function automatic logic [NUM_CHANNELS-1:0] rst_from(input logic [CW-1:0] idx);
    logic [NUM_CHANNELS-1:0] m;
    for (int j = 0; j < NUM_CHANNELS; j++) m[j] = (CW'(j) >= idx);
    return m;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_HOLD;
      chan          <= '0;
      hold_cnt      <= '0;
      wait_cnt      <= '0;
      stag_cnt      <= '0;
      limit_q       <= '0;
      limit_valid_q <= 1'b0;
      chan_rst      <= '1;
      ready         <= 1'b0;
      timeout_err   <= 1'b0;
      err_chan      <= '0;
      cycle_count   <= '0;
      finish        <= 1'b0;
    end else if (sw_reset_req) begin
      state         <= S_HOLD;
      chan          <= '0;
      hold_cnt      <= '0;
      wait_cnt      <= '0;
      stag_cnt      <= '0;
      limit_q       <= '0;
      limit_valid_q <= 1'b0;
      chan_rst      <= '1;
      ready         <= 1'b0;
      timeout_err   <= 1'b0;
      err_chan      <= '0;
      cycle_count   <= '0;
      finish        <= 1'b0;
    end else begin
      case (state)
        S_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            chan     <= '0;
            wait_cnt <= '0;
            chan_rst <= rst_from(CW'(1));
            state    <= S_RELEASE;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end

        S_RELEASE: begin
          if (ack_cur) begin
            stag_cnt <= '0;
            state    <= (chan == LAST_CHAN) ? S_ARM : S_STAGGER;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_err <= 1'b1;
            err_chan    <= chan;
            chan_rst    <= rst_from(chan);
            state       <= S_ERROR;
          end else begin
            wait_cnt <= wait_cnt + AW'(1);
          end
        end

        S_STAGGER: begin
          if (stag_cnt == STAG_LAST) begin
            chan     <= chan + CW'(1);
            wait_cnt <= '0;
            chan_rst <= rst_from(chan + CW'(2));
            state    <= S_RELEASE;
          end else begin
            stag_cnt <= stag_cnt + SW'(1);
          end
        end

        S_ARM: begin
          ready         <= 1'b1;
          limit_q       <= cycle_limit;
          limit_valid_q <= cycle_limit_valid;
          cycle_count   <= '0;
          // A zero limit finishes on the same edge ready rises.
          if (cycle_limit_valid && cycle_limit == '0) begin
            finish <= 1'b1;
            state  <= S_DONE;
          end else begin
            state <= S_RUN;
          end
        end

        S_RUN: begin
          if (cycle_count != CNT_MAX) begin
            cycle_count <= cnt_next;
            if (limit_valid_q && cnt_next == limit_q) begin
              finish <= 1'b1;
              state  <= S_DONE;
            end
          end
        end

        S_DONE, S_ERROR: begin
          state <= state;
        end

        default: begin
          state <= S_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cosim_reset_sequencer.sv
// Bench for cosim_reset_sequencer: randomized ack timing and limits checked edge by edge
// against an edge-arithmetic model of the release schedule.
module tb_cosim_reset_sequencer;

  localparam int NCH   = 2;
  localparam int HOLD  = 4;
  localparam int STAG  = 1;
  localparam int TMO   = 8;
  localparam int CNTW  = 8;
  localparam int CHW   = $clog2(NCH) + 1;
  localparam int CMAX  = (1 << CNTW) - 1;
  localparam int NEVER = 1 << 28;

  logic              clk;
  logic              rst_n;
  logic [CNTW-1:0]   cycle_limit;
  logic              cycle_limit_valid;
  logic              sw_reset_req;
  logic [NCH-1:0]    chan_rst_ack;
  logic [NCH-1:0]    chan_rst;
  logic              ready;
  logic              timeout_err;
  logic [CHW-1:0]    err_chan;
  logic [CNTW-1:0]   cycle_count;
  logic              finish;
  logic [2:0]        state_dbg;

  typedef struct packed {
    logic [NCH-1:0]  rst;
    logic            rdy;
    logic            to;
    logic [CHW-1:0]  ch;
    logic [CNTW-1:0] cnt;
    logic            fin;
  } out_t;

  int compared = 0;
  int failed   = 0;

  // Scenario schedule, in edges counted from the first edge out of reset.
  int sc_d[NCH];
  int sc_lim;
  bit sc_vld;
  int rel[NCH];
  int kk[NCH];
  int err_e, err_c, rdy;

  cosim_reset_sequencer #(
    .NUM_CHANNELS(NCH), .HOLD_CYCLES(HOLD), .STAGGER_CYCLES(STAG),
    .ACK_TIMEOUT(TMO), .CYCLE_CNT_WIDTH(CNTW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cycle_limit(cycle_limit),
    .cycle_limit_valid(cycle_limit_valid), .sw_reset_req(sw_reset_req),
    .chan_rst_ack(chan_rst_ack), .chan_rst(chan_rst), .ready(ready),
    .timeout_err(timeout_err), .err_chan(err_chan), .cycle_count(cycle_count),
    .finish(finish), .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic set_scenario(input int d0, input int d1, input int lim, input bit vld);
    int t;
    bit dead;
    sc_d[0] = d0;
    sc_d[1] = d1;
    sc_lim  = lim;
    sc_vld  = vld;
    err_e = NEVER; err_c = 0; rdy = NEVER; dead = 1'b0; t = HOLD;
    for (int i = 0; i < NCH; i++) begin
      rel[i] = NEVER;
      kk[i]  = NEVER;
      if (!dead) begin
        rel[i] = t;
        if (sc_d[i] > TMO) begin
          err_e = t + TMO;
          err_c = i;
          dead  = 1'b1;
        end else begin
          kk[i] = t + sc_d[i];
          t = kk[i] + STAG;
          if (i == NCH - 1) rdy = kk[i] + 1;
        end
      end
    end
  endtask

  function automatic out_t model(input int n);
    out_t e;
    int el;
    for (int j = 0; j < NCH; j++) e.rst[j] = (n < rel[j]) || (n >= err_e && j >= err_c);
    e.rdy = (n >= rdy);
    e.to  = (n >= err_e);
    e.ch  = e.to ? CHW'(err_c) : '0;
    e.cnt = '0;
    e.fin = 1'b0;
    if (n >= rdy) begin
      el = n - rdy;
      if (sc_vld && el > sc_lim) el = sc_lim;
      if (el > CMAX) el = CMAX;
      e.cnt = CNTW'(el);
      e.fin = sc_vld && (n - rdy >= sc_lim);
    end
    return e;
  endfunction

  function automatic out_t reset_val();
    out_t e;
    e = '0;
    e.rst = '1;
    return e;
  endfunction

  function automatic out_t observe();
    out_t o;
    o.rst = chan_rst;
    o.rdy = ready;
    o.to  = timeout_err;
    o.ch  = err_chan;
    o.cnt = cycle_count;
    o.fin = finish;
    return o;
  endfunction

  // Driver: one edge n of the scenario; acks stay low until their scheduled edge, then wander.
  task automatic step(input int n, input bit sw);
    @(negedge clk);
    sw_reset_req      = sw;
    cycle_limit       = CNTW'(sc_lim);
    cycle_limit_valid = sc_vld;
    for (int i = 0; i < NCH; i++) begin
      if (sw)              chan_rst_ack[i] = 1'b1;
      else if (n < kk[i])  chan_rst_ack[i] = 1'b0;
      else if (n == kk[i]) chan_rst_ack[i] = 1'b1;
      else                 chan_rst_ack[i] = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    out_t got;
    repeat (2) @(posedge clk);
    #1;
    got = observe();
    compared++;
    if (got !== reset_val()) begin
      failed++;
      $display("FAIL reset got=%h exp=%h", got, reset_val());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_sequence();
    out_t got, exp;
    set_scenario(2, 3, 10, 1'b1);
    for (int n = 1; n <= rdy + 15; n++) begin
      step(n, n == rdy + 15);
      got = observe();
      exp = (n == rdy + 15) ? reset_val() : model(n);
      compared++;
      if (got !== exp) begin
        failed++;
        $display("FAIL basic n=%0d got=%h exp=%h", n, got, exp);
      end
    end
  endtask

  task automatic test_limit_zero();
    out_t got, exp;
    set_scenario($urandom_range(1, TMO), $urandom_range(1, TMO), 0, 1'b1);
    for (int n = 1; n <= rdy + 5; n++) begin
      step(n, n == rdy + 5);
      got = observe();
      exp = (n == rdy + 5) ? reset_val() : model(n);
      compared++;
      if (got !== exp) begin
        failed++;
        $display("FAIL limit_zero n=%0d got=%h exp=%h", n, got, exp);
      end
    end
  endtask

  task automatic test_timeout();
    out_t got, exp;
    set_scenario(1, NEVER, 5, 1'b1);
    for (int n = 1; n <= err_e + 6; n++) begin
      step(n, n == err_e + 6);
      got = observe();
      exp = (n == err_e + 6) ? reset_val() : model(n);
      compared++;
      if (got !== exp) begin
        failed++;
        $display("FAIL timeout n=%0d got=%h exp=%h", n, got, exp);
      end
    end
  endtask

  task automatic test_ack_boundary();
    out_t got, exp;
    int len;
    for (int k = 0; k < 2; k++) begin
      set_scenario(TMO + k, 1, 2, 1'b1);
      len = (k == 0) ? rdy + 4 : err_e + 3;
      for (int n = 1; n <= len; n++) begin
        step(n, n == len);
        got = observe();
        exp = (n == len) ? reset_val() : model(n);
        compared++;
        if (got !== exp) begin
          failed++;
          $display("FAIL ack_boundary k=%0d n=%0d got=%h exp=%h", k, n, got, exp);
        end
      end
    end
  endtask

  task automatic test_sw_reset();
    out_t got, exp;
    int len;
    set_scenario(2, 3, 10, 1'b1);
    // Phase 0: sw on the ack[1] edge; 1: sw in RUN; 2: full replay to DONE.
    for (int p = 0; p < 3; p++) begin
      len = (p == 0) ? kk[1] : (p == 1) ? rdy + 4 : rdy + 12;
      for (int n = 1; n <= len; n++) begin
        step(n, n == len);
        got = observe();
        exp = (n == len) ? reset_val() : model(n);
        compared++;
        if (got !== exp) begin
          failed++;
          $display("FAIL sw_reset p=%0d n=%0d got=%h exp=%h", p, n, got, exp);
        end
      end
    end
  endtask

  task automatic test_saturate();
    out_t got, exp;
    set_scenario(1, 2, 3, 1'b0);
    for (int n = 1; n <= rdy + CMAX + 10; n++) begin
      step(n, n == rdy + CMAX + 10);
      got = observe();
      exp = (n == rdy + CMAX + 10) ? reset_val() : model(n);
      compared++;
      if (got !== exp) begin
        failed++;
        $display("FAIL saturate n=%0d got=%h exp=%h", n, got, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    out_t got, exp;
    set_scenario(2, 3, 10, 1'b1);
    for (int n = 1; n <= rel[1] + 1; n++) begin
      step(n, 1'b0);
      got = observe();
      exp = model(n);
      compared++;
      if (got !== exp) begin
        failed++;
        $display("FAIL async_pre n=%0d got=%h exp=%h", n, got, exp);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    got = observe();
    compared++;
    if (got !== reset_val()) begin
      failed++;
      $display("FAIL async_assert got=%h exp=%h", got, reset_val());
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int n = 1; n <= rdy + 3; n++) begin
      step(n, n == rdy + 3);
      got = observe();
      exp = (n == rdy + 3) ? reset_val() : model(n);
      compared++;
      if (got !== exp) begin
        failed++;
        $display("FAIL async_replay n=%0d got=%h exp=%h", n, got, exp);
      end
    end
  endtask

  task automatic test_random();
    out_t got, exp;
    int horizon, len;
    repeat (12) begin
      set_scenario($urandom_range(1, TMO + 2), $urandom_range(1, TMO + 2),
                   $urandom_range(0, 30), 1'($urandom_range(0, 1)));
      horizon = (rdy != NEVER) ? rdy + (sc_vld ? sc_lim : 10) : err_e;
      len = $urandom_range(1, horizon + 4);
      for (int n = 1; n <= len; n++) begin
        step(n, n == len);
        got = observe();
        exp = (n == len) ? reset_val() : model(n);
        compared++;
        if (got !== exp) begin
          failed++;
          $display("FAIL random n=%0d len=%0d got=%h exp=%h", n, len, got, exp);
        end
      end
    end
  endtask

  initial begin
    rst_n             = 1'b0;
    sw_reset_req      = 1'b0;
    chan_rst_ack      = '0;
    cycle_limit       = '0;
    cycle_limit_valid = 1'b0;
    sc_lim            = 0;
    sc_vld            = 1'b0;
    for (int i = 0; i < NCH; i++) kk[i] = NEVER;

    test_reset();
    test_basic_sequence();
    test_limit_zero();
    test_timeout();
    test_ack_boundary();
    test_sw_reset();
    test_saturate();
    test_async_reset();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
